// File: rtl/mppc_window_scheduler_if.sv
// Readout stream between the MPPC window scheduler and host-side logic.
// One snapshot channel per transfer on a valid/ready handshake.
interface mppc_window_scheduler_if #(
    parameter int CHW = 2,
    parameter int CW  = 12
);
    logic           out_valid;
    logic           out_ready;
    logic [CHW-1:0] out_channel;
    logic [CW-1:0]  out_count;
    logic [15:0]    out_seq;
    logic           out_last;

    modport master (
        output out_valid, out_channel, out_count, out_seq, out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_channel, out_count, out_seq, out_last,
        output out_ready
    );
endinterface

// File: rtl/mppc_window_scheduler.sv
// MPPC channel controller: boot pad enable, fixed counting windows,
// per-channel hit counting, snapshot and streamed readout.
module mppc_window_scheduler #(
    parameter int NCH        = 4,
    parameter int CHW        = 2,
    parameter int CW         = 12,
    parameter int WINDOW     = 1000000,
    parameter int WIN_W      = 32,
    parameter int BOOT_DELAY = 1024
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       run,
    input  logic [NCH-1:0]             hit_in,
    output logic [NCH-1:0]             ch_enable,
    output logic                       win_tick,
    mppc_window_scheduler_if.master    rd,
    output logic                       busy,
    output logic [7:0]                 drop_cnt
);

    localparam int BW = $clog2(BOOT_DELAY + 1);
    localparam logic [BW-1:0]    BLAST = BW'(BOOT_DELAY - 1);
    localparam logic [WIN_W-1:0] WLAST = WIN_W'(WINDOW - 1);
    localparam logic [CHW-1:0]   CLAST = CHW'(NCH - 1);
    localparam logic [CW-1:0]    CMAX  = '1;

    typedef enum logic [1:0] {
        BOOT,
        IDLE,
        RUN
    } state_t;

    state_t           state;
    logic [BW-1:0]    boot_cnt;
    logic [WIN_W-1:0] win_cnt;
    logic [WIN_W-1:0] win_nxt;
    logic [15:0]      seq;
    logic [15:0]      seq_lat;
    logic             valid_q;
    logic [CHW-1:0]   rd_ch;

    logic [NCH-1:0]   s1;
    logic [NCH-1:0]   s2;
    logic [NCH-1:0]   s3;
    logic [NCH-1:0]   rise;

    logic [CW-1:0]    acc      [NCH];
    logic [CW-1:0]    acc_inc  [NCH];
    logic [CW-1:0]    snap     [NCH];

    // win_tick is only ever set while staying in RUN, so it marks
    // a completed window even if run drops on that last cycle.
    logic snap_now;
    logic acc_clr;

    assign rise     = s2 & ~s3;
    assign snap_now = win_tick;
    assign acc_clr  = (state != RUN) || !run || snap_now;
    assign win_nxt  = (win_cnt == WLAST) ? '0 : win_cnt + 1'b1;

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            acc_inc[i] = acc[i];
            if (state == RUN && rise[i] && acc[i] != CMAX)
                acc_inc[i] = acc[i] + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= BOOT;
            boot_cnt  <= '0;
            ch_enable <= '0;
            win_cnt   <= '0;
            win_tick  <= 1'b0;
        end else begin
            win_tick <= 1'b0;
            unique case (state)
                BOOT: begin
                    if (boot_cnt == BLAST) begin
                        ch_enable <= '1;
                        state     <= IDLE;
                    end else begin
                        boot_cnt <= boot_cnt + 1'b1;
                    end
                end
                IDLE: begin
                    if (run) begin
                        win_cnt <= '0;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    if (!run) begin
                        state <= IDLE;
                    end else begin
                        win_cnt  <= win_nxt;
                        win_tick <= (win_nxt == WLAST);
                    end
                end
                default: state <= BOOT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= '0;
            s2 <= '0;
            s3 <= '0;
            for (int i = 0; i < NCH; i++) begin
                acc[i] <= '0;
            end
        end else begin
            s1 <= hit_in;
            s2 <= s1;
            s3 <= s2;
            for (int i = 0; i < NCH; i++) begin
                acc[i] <= acc_clr ? '0 : acc_inc[i];
            end
        end
    end

    // A snapshot while busy is discarded; the last transfer frees busy
    // only from the following cycle, so a coincident snapshot drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seq      <= '0;
            seq_lat  <= '0;
            busy     <= 1'b0;
            valid_q  <= 1'b0;
            rd_ch    <= '0;
            drop_cnt <= '0;
            for (int i = 0; i < NCH; i++) begin
                snap[i] <= '0;
            end
        end else begin
            if (snap_now) begin
                seq <= seq + 1'b1;
                if (!busy) begin
                    snap    <= acc_inc;
                    seq_lat <= seq;
                    busy    <= 1'b1;
                    valid_q <= 1'b1;
                    rd_ch   <= '0;
                end else if (drop_cnt != 8'hFF) begin
                    drop_cnt <= drop_cnt + 1'b1;
                end
            end
            if (valid_q && rd.out_ready) begin
                if (rd_ch == CLAST) begin
                    valid_q <= 1'b0;
                    busy    <= 1'b0;
                end else begin
                    rd_ch <= rd_ch + 1'b1;
                end
            end
        end
    end

    assign rd.out_valid   = valid_q;
    assign rd.out_channel = rd_ch;
    assign rd.out_count   = snap[rd_ch];
    assign rd.out_seq     = seq_lat;
    assign rd.out_last    = valid_q && (rd_ch == CLAST);

endmodule
